mat_result_streamer: RTL and testbench
======================================

# mat_result_streamer

Output-side companion of the systolic matrix-multiply control unit. On the control unit's done pulse it captures the flattened N×N result matrix into a shadow register. It then streams the elements out one per valid/ready handshake in row-major order. This frees the control unit to start the next multiplication while the previous result drains to a narrow consumer (host bridge, FIFO, debug port).

## Interface
Parameters:
- W, 16, element width in bits (fp16 bit pattern, passed through untouched)
- N, 3, matrix dimension; BIT_MAT_DIM = W*N*N
- IW, $clog2(N) (min 1), width of row/col index outputs

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_done  input  1  one-cycle pulse from control unit: i_C valid this cycle
- i_C  input  BIT_MAT_DIM  flattened result matrix
- o_data  output  W  current element
- o_valid  output  1  o_data/o_row/o_col/o_last valid
- i_ready  input  1  consumer accepts the element this cycle
- o_row  output  IW  row of current element
- o_col  output  IW  column of current element
- o_last  output  1  current element is (N-1,N-1)
- o_busy  output  1  shadow register holds undrained data
- o_overrun  output  1  sticky: a result was dropped

## Operation
- Packing: element (r,c) occupies i_C[(N*N-1-(r*N+c))*W +: W], so (0,0) sits in the MSBs. This matches how A/B are packed into the control unit.
- FSM states:
  - IDLE: o_valid=0, o_busy=0.
    - i_done → capture i_C into shadow, row=col=0, go to STREAM.
  - STREAM: o_valid=1, o_busy=1. o_data = shadow element (row,col).
    - Handshake (o_valid & i_ready) advances col; col wraps N-1→0 with row+1.
    - Handshake with o_last=1:
      - If i_done is high in the same cycle, recapture i_C, reset indices to 0, and stay in STREAM (back-to-back, no bubble).
      - Otherwise go to IDLE.
- i_done in STREAM without a concurrent last handshake: the new result is dropped, the shadow register is unchanged, and o_overrun is set. o_overrun clears only on reset.
- i_done while i_rst_n is low: ignored.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: o_valid=0, o_busy=0, o_last=0, o_overrun=0, o_row=0, o_col=0, o_data=0.
- Reset asserted mid-stream: outputs go to reset values immediately (async). Remaining elements are lost. After release the FSM is in IDLE.
- Capture latency: i_done sampled at edge k → o_valid=1 with element (0,0) from edge k through at least edge k+1.
- Throughput: one element per cycle while i_ready=1. A full matrix drains in N*N cycles minimum.
- Stall: while o_valid & !i_ready, o_data, o_row, o_col and o_last hold stable.
- Protocol rules:
  - o_valid never drops without a handshake.
  - o_valid does not depend combinationally on i_ready.
- o_last is high exactly when row=N-1 and col=N-1 and o_valid=1.
- Back-to-back: a last handshake and i_done in the same cycle give element (0,0) of the new matrix on the next cycle. o_valid stays high throughout.

## Structure
- Shared package (shared with the control unit):
  - localparams for the W=16, N=3 defaults and BIT_MAT_DIM
  - element-offset function elem_lsb(r,c) implementing the packing rule
  - FSM state typedef {IDLE, STREAM}
- One natural sub-module: mat_rc_counter. It is the row/col wrap counter with increment, clear and last outputs, and is reusable for the input-side loader.
- Element mux: plain indexed part-select on the shadow register, no sub-module.

## Test plan
- Basic drain: W=16, N=3, i_C elements (0,0)..(2,2) = 16'h0001..16'h0009, i_done pulse, i_ready=1 → o_data 0001..0009 on 9 consecutive cycles. o_last only with 0009. o_valid=0 on the 10th cycle.
- Backpressure: same data, i_ready toggling 1,0,0,1,… → every element appears exactly once in order and holds stable during stalls. Row/col sequence is (0,0),(0,1),(0,2),(1,0),…,(2,2).
- Back-to-back: during the handshake of 0009, pulse i_done with elements 16'h3c00 → the next cycle shows 3c00 at (0,0). No o_valid gap, o_overrun=0.
- Overrun: pulse i_done again while element 0004 is pending → stream continues 0004..0009 unchanged. o_overrun=1 and stays 1 after returning to IDLE.
- Reset mid-stream: drop i_rst_n asynchronously while presenting 0005 → all outputs go to 0 immediately. After release, the next i_done streams the new matrix from (0,0).
- Idle noise: i_ready=1 with no i_done for 20 cycles → o_valid stays 0 and o_busy stays 0.

Source files
------------

// File: rtl/mat_result_streamer_pkg.sv
// Shared definitions for the systolic matmul control unit and its result streamer.
// Holds default geometry, the matrix packing rule and the streamer FSM state type.
package mat_result_streamer_pkg;

   localparam int unsigned MAT_W       = 16;
   localparam int unsigned MAT_N       = 3;
   localparam int unsigned BIT_MAT_DIM = MAT_W * MAT_N * MAT_N;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   // Element (0,0) sits in the MSBs; row-major order walks towards the LSBs.
   function automatic int unsigned elem_lsb(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned n,
                                            input int unsigned w);
      return (n * n - 1 - (r * n + c)) * w;
   endfunction

endpackage

// File: rtl/mat_rc_counter.sv
// Row/column wrap counter for walking an N x N matrix in row-major order.
// Clear has priority over increment; last_o flags position (N-1,N-1).
module mat_rc_counter #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [IW-1:0] row_o,
   output logic [IW-1:0] col_o,
   output logic          last_o
);

   localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

   logic [IW-1:0] row_q, row_d;
   logic [IW-1:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
      end else if (inc_i) begin
         if (col_q == IDX_MAX) begin
            col_d = '0;
            row_d = (row_q == IDX_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (row_q == IDX_MAX) && (col_q == IDX_MAX);

endmodule

// File: rtl/mat_result_streamer.sv
// Captures the control unit's N x N result on i_done and drains it one element per
// valid/ready handshake in row-major order; a done arriving mid-drain is dropped (sticky overrun).
module mat_result_streamer
   import mat_result_streamer_pkg::*;
#(
   parameter int W  = MAT_W,
   parameter int N  = MAT_N,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_done,
   input  logic [W*N*N-1:0]  i_C,
   output logic [W-1:0]      o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [IW-1:0]     o_row,
   output logic [IW-1:0]     o_col,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_overrun
);

   localparam int BITS = W * N * N;

   state_e            state_q, state_d;
   logic [BITS-1:0]   shadow_q, shadow_d;
   logic              overrun_q, overrun_d;

   logic              cnt_clr, cnt_inc, cnt_last;
   logic [IW-1:0]     row, col;
   logic              valid, hs, last_hs;
   logic [W-1:0]      elem;

   assign valid   = (state_q == STREAM);
   assign hs      = valid & i_ready;
   assign last_hs = hs & cnt_last;

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      overrun_d = overrun_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_done) begin
               shadow_d = i_C;
               cnt_clr  = 1'b1;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (last_hs) begin
               // Indices return to (0,0) either for the next matrix or for idle.
               cnt_clr = 1'b1;
               if (i_done) begin
                  shadow_d = i_C;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_inc = hs;
               if (i_done) begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         overrun_q <= overrun_d;
      end
   end

   mat_rc_counter #(
      .N  (N),
      .IW (IW)
   ) u_rc (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .row_o  (row),
      .col_o  (col),
      .last_o (cnt_last)
   );

   always_comb begin
      elem = shadow_q[elem_lsb(32'(row), 32'(col), N, W) +: W];
   end

   assign o_valid   = valid;
   assign o_busy    = valid;
   assign o_data    = valid ? elem : '0;
   assign o_row     = row;
   assign o_col     = col;
   assign o_last    = valid & cnt_last;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed and random checks of mat_result_streamer against a queue-based model of the drain order.
module tb_mat_result_streamer;

   localparam int W    = 16;
   localparam int N    = 3;
   localparam int IW   = 2;
   localparam int BITS = W * N * N;

   logic              clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_done = 1'b0;
   logic [BITS-1:0]   i_C = '0;
   logic              i_ready = 1'b0;
   logic [W-1:0]      o_data;
   logic              o_valid;
   logic [IW-1:0]     o_row;
   logic [IW-1:0]     o_col;
   logic              o_last;
   logic              o_busy;
   logic              o_overrun;

   always #5 clk = ~clk;

   mat_result_streamer #(.W(W), .N(N), .IW(IW)) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_done    (i_done),
      .i_C       (i_C),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_row     (o_row),
      .o_col     (o_col),
      .o_last    (o_last),
      .o_busy    (o_busy),
      .o_overrun (o_overrun)
   );

   typedef struct {
      logic [W-1:0] d;
      int           r;
      int           c;
      bit           l;
   } exp_t;

   exp_t         q[$];
   bit           ov_m = 1'b0;
   logic [W-1:0] vals [N*N];
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [BITS-1:0] pack_vals();
      logic [BITS-1:0] c;
      c = '0;
      for (int k = 0; k < N * N; k++) c[(N*N-1-k)*W +: W] = vals[k];
      return c;
   endfunction

   task automatic set_seq(input int base);
      for (int k = 0; k < N * N; k++) vals[k] = W'(base + k);
   endtask

   task automatic set_rand();
      for (int k = 0; k < N * N; k++) vals[k] = W'($urandom);
   endtask

   task automatic compare_outs();
      chk("valid", 32'(o_valid), 32'(q.size() > 0));
      chk("busy", 32'(o_busy), 32'(q.size() > 0));
      chk("overrun", 32'(o_overrun), 32'(ov_m));
      if (q.size() > 0) begin
         chk("data", 32'(o_data), 32'(q[0].d));
         chk("row", 32'(o_row), 32'(q[0].r));
         chk("col", 32'(o_col), 32'(q[0].c));
         chk("last", 32'(o_last), 32'(q[0].l));
      end else begin
         chk("last_idle", 32'(o_last), 32'd0);
      end
   endtask

   // One cycle: check what the DUT shows now, then apply inputs for the next edge.
   task automatic drive(input bit done, input bit rdy);
      logic [BITS-1:0] c;
      @(negedge clk);
      compare_outs();
      if (done) c = pack_vals();
      else for (int k = 0; k < N * N; k++) c[k*W +: W] = W'($urandom);
      i_done  = done;
      i_C     = c;
      i_ready = rdy;
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (done) begin
         if (q.size() == 0) begin
            for (int k = 0; k < N * N; k++) q.push_back('{vals[k], k / N, k % N, k == N * N - 1});
         end else begin
            ov_m = 1'b1;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_last"}, 32'(o_last), 32'd0);
      chk({tag, "_ovr"}, 32'(o_overrun), 32'd0);
      chk({tag, "_row"}, 32'(o_row), 32'd0);
      chk({tag, "_col"}, 32'(o_col), 32'd0);
      chk({tag, "_data"}, 32'(o_data), 32'd0);
   endtask

   initial begin
      #12;
      check_all_zero("reset");
      @(negedge clk);
      i_rst_n = 1'b1;

      // Basic drain
      set_seq(1);
      drive(1, 1);
      repeat (11) drive(0, 1);

      // Backpressure 1,0,0,1,...
      set_seq(1);
      drive(1, 1);
      for (int i = 0; i < 32; i++) drive(0, (i % 4 == 0) || (i % 4 == 3));
      repeat (4) drive(0, 1);

      // Back-to-back: done alongside the handshake of element (2,2)
      set_seq(1);
      drive(1, 1);
      repeat (8) drive(0, 1);
      set_seq(16'h3c00);
      drive(1, 1);
      repeat (11) drive(0, 1);

      // Overrun: done while 0004 is pending
      set_seq(1);
      drive(1, 1);
      repeat (3) drive(0, 1);
      set_seq(16'h7000);
      drive(1, 0);
      repeat (12) drive(0, 1);

      // Reset mid-stream while 0005 is presented
      set_seq(1);
      drive(1, 1);
      repeat (4) drive(0, 1);
      drive(0, 0);
      @(negedge clk);
      compare_outs();
      #2 i_rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      q.delete();
      ov_m = 1'b0;
      @(negedge clk);
      i_done = 1'b1;
      @(negedge clk);
      i_done  = 1'b0;
      i_rst_n = 1'b1;
      drive(0, 1);
      set_seq(16'h0100);
      drive(1, 1);
      repeat (11) drive(0, 1);

      // Idle noise
      repeat (20) drive(0, 1);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         bit d;
         d = ($urandom_range(0, 7) == 0);
         if (d) set_rand();
         drive(d, $urandom_range(0, 3) != 0);
      end
      repeat (20) drive(0, 1);
      @(negedge clk);
      compare_outs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
